// File: rtl/ext_pipe.sv
// Pipelined extend unit: immediate zero/sign/high extension and
// lb/lbu/lh/lhu lane extraction behind a valid/ready FIFO buffer.
//
// Ports:
//   clk, reset (async, active-low), flush (sync drop of all entries)
//   in_valid/in_ready, in_op[2:0], in_data[OUT_W], in_addr[1:0]
//   out_valid/out_ready, out_data[OUT_W], out_aerr
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [OUT_W-1:0] in_data,
  input  logic [1:0]       in_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_aerr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [2:0] OP_ZERO = 3'd0;
  localparam logic [2:0] OP_SIGN = 3'd1;
  localparam logic [2:0] OP_HIGH = 3'd2;
  localparam logic [2:0] OP_LBU  = 3'd3;
  localparam logic [2:0] OP_LB   = 3'd4;
  localparam logic [2:0] OP_LHU  = 3'd5;
  localparam logic [2:0] OP_LH   = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_amem;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_aerr;

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_high;
  logic [OUT_W-1:0] w_res;
  logic             w_aerr;

  logic             w_acc;
  logic             w_pop;
  logic             w_wr;
  logic             w_rd;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_rd_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [OUT_W-1:0] w_head_d;
  logic             w_head_a;

  // Result is formed at accept time and stored, so the buffer holds
  // finished values and the head path is a plain register.
  always_comb begin
    w_byte = in_data[{in_addr, 3'b000} +: 8];
    w_half = in_data[{in_addr[1], 4'b0000} +: 16];
    w_zext = OUT_W'(in_data[IN_W-1:0]);
    w_sext = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_sext[i] = (i < IN_W) ? in_data[i] : in_data[IN_W-1];
    end
    w_high = w_zext << (OUT_W - IN_W);
    w_res  = in_data;
    w_aerr = 1'b0;
    case (in_op)
      OP_ZERO: w_res = w_zext;
      OP_SIGN: w_res = w_sext;
      OP_HIGH: w_res = w_high;
      OP_LBU:  w_res = {{(OUT_W-8){1'b0}}, w_byte};
      OP_LB:   w_res = {{(OUT_W-8){w_byte[7]}}, w_byte};
      OP_LHU: begin
        w_res  = {{(OUT_W-16){1'b0}}, w_half};
        w_aerr = in_addr[0];
      end
      OP_LH: begin
        w_res  = {{(OUT_W-16){w_half[15]}}, w_half};
        w_aerr = in_addr[0];
      end
      OP_PASS: w_res = in_data;
      default: w_res = in_data;
    endcase
  end

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign out_data  = r_out_data;
  assign out_aerr  = r_out_aerr;

  assign w_acc = in_valid & in_ready;
  assign w_pop = out_valid & out_ready;
  assign w_wr  = w_acc & ~flush;
  assign w_rd  = w_pop & ~flush;

  always_comb begin
    w_wr_nxt  = flush ? '0 : r_wr_ptr + PW'(w_wr);
    w_rd_nxt  = flush ? '0 : r_rd_ptr + PW'(w_rd);
    w_cnt_nxt = flush ? '0 : r_count + CW'(w_wr) - CW'(w_rd);
    // The entry being written this cycle becomes the head when every
    // older entry has left; it is not in r_mem yet, so bypass it.
    if (w_wr && (w_rd_nxt == r_wr_ptr)) begin
      w_head_d = w_res;
      w_head_a = w_aerr;
    end else begin
      w_head_d = r_mem[w_rd_nxt];
      w_head_a = r_amem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_amem     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_out_data <= '0;
      r_out_aerr <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr]  <= w_res;
        r_amem[r_wr_ptr] <= w_aerr;
      end
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      // Empty buffer keeps showing the last head value.
      if (w_cnt_nxt != '0) begin
        r_out_data <= w_head_d;
        r_out_aerr <= w_head_a;
      end
    end
  end

endmodule
